// File: rtl/divu_sequencer_if.sv
// Handshake bundle between the EX/ID pipeline control and the DIVU sequencer.
// master = pipeline side, slave = divider side.
interface divu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic             kill;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             id_mfhilo;
  logic             id_div;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             stall;

  modport master (
    output div_start, kill, dividend, divisor, id_mfhilo, id_div,
    input  hi, lo, busy, done, div_by_zero, stall
  );

  modport slave (
    input  div_start, kill, dividend, divisor, id_mfhilo, id_div,
    output hi, lo, busy, done, div_by_zero, stall
  );
endinterface

// File: rtl/divu_sequencer.sv
// Multi-cycle restoring unsigned divider owning HI/LO, with the ID-stage interlock stall.
// Optional macro DIVU_EARLY_OUT_EN: skip RUN when divisor==0 or dividend<divisor.
//
// state | meaning
// IDLE  | waiting for an unkilled div_start
// RUN   | one shift-subtract step per cycle, WIDTH steps
// DONE  | done pulse; HI/LO written at the closing edge
module divu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  divu_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   rem, quot, dvsr;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               accept, early;
  logic [WIDTH:0]     t_hi;
  logic               ge;
  logic [WIDTH-1:0]   rem_sub;

  assign accept = bus.div_start && !bus.kill && (state == IDLE);

`ifdef DIVU_EARLY_OUT_EN
  assign early = (bus.divisor == '0) || (bus.dividend < bus.divisor);
`else
  assign early = 1'b0;
`endif

  // Partial remainder is WIDTH+1 bits after the shift; since rem < dvsr the
  // difference always fits in WIDTH bits, so a WIDTH-bit subtract suffices.
  assign t_hi    = {rem, quot[WIDTH-1]};
  assign ge      = t_hi >= {1'b0, dvsr};
  assign rem_sub = t_hi[WIDTH-1:0] - dvsr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early ? DONE : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.div_by_zero = (state == DONE) && (dvsr == '0);
    bus.stall       = (accept || state == RUN) && (bus.id_mfhilo || bus.id_div);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      quot <= '0;
      dvsr <= '0;
      cnt  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvsr <= bus.divisor;
          if (early) begin
            rem  <= bus.dividend;
            quot <= (bus.divisor == '0) ? '1 : '0;
            cnt  <= '0;
          end else begin
            rem  <= '0;
            quot <= bus.dividend;
            cnt  <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          rem  <= ge ? rem_sub : t_hi[WIDTH-1:0];
          quot <= {quot[WIDTH-2:0], ge};
          cnt  <= cnt - 1'b1;
        end
        DONE: begin
          hi_q <= rem;
          lo_q <= quot;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_divu_sequencer.sv
// Self-checking bench for divu_sequencer: directed cases plus random divides
// compared against plain '/' and '%' arithmetic.
module tb_divu_sequencer;
  localparam int W = 32;
`ifdef DIVU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divu_sequencer_if #(.WIDTH(W)) bus();
  divu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input bit hold_mf, input bit hold_div, input bit inject);
    logic [W-1:0] q_exp, r_exp;
    int  lat;
    bit  seen;
    logic rq;
    q_exp = (dvs == 0) ? '1  : dvd / dvs;
    r_exp = (dvs == 0) ? dvd : dvd % dvs;
    lat   = (EARLY && (dvs == 0 || dvd < dvs)) ? 0 : W;
    rq    = hold_mf | hold_div;
    seen  = 1'b0;
    @(negedge clk);
    bus.div_start = 1'b1; bus.kill = 1'b0;
    bus.dividend  = dvd;  bus.divisor = dvs;
    bus.id_mfhilo = hold_mf; bus.id_div = hold_div;
    #1 chk("stall_start", bus.stall, rq);
    for (int i = 0; i <= W + 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.div_start = inject && (i == 9);
      if (inject && i == 9) begin
        bus.dividend = $urandom;
        bus.divisor  = $urandom_range(1, 50);
      end
      #1;
      if (bus.done) begin
        chk("latency", i, lat);
        seen = 1'b1;
        break;
      end
      chk("busy_run", bus.busy, 1);
      chk("stall_run", bus.stall, rq);
      chk("hi_hold", bus.hi, m_hi);
      chk("lo_hold", bus.lo, m_lo);
    end
    bus.div_start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      chk("stall_done", bus.stall, 0);
      chk("dbz_done", bus.div_by_zero, (dvs == 0));
      chk("lo_before_done_edge", bus.lo, m_lo);
      m_hi = r_exp;
      m_lo = q_exp;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("busy_after", bus.busy, 0);
      chk("done_after", bus.done, 0);
      chk("dbz_after", bus.div_by_zero, 0);
      chk("stall_idle", bus.stall, 0);
    end
    bus.id_mfhilo = 1'b0;
    bus.id_div    = 1'b0;
  endtask

  initial begin
    int saw_done;
    logic [W-1:0] dvd, dvs;
    bus.div_start = 0; bus.kill = 0; bus.dividend = 0; bus.divisor = 0;
    bus.id_mfhilo = 0; bus.id_div = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 0, 0, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 1, 0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0);
    run_div(32'h1234, 32'd0, 1, 0, 0);
    run_div(32'd1000, 32'd13, 1, 0, 1);

    // Reset in the middle of a divide: no done pulse, HI/LO cleared.
    @(negedge clk);
    bus.div_start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_hi", bus.hi, 0);
    chk("rst_mid_lo", bus.lo, 0);
    m_hi = '0; m_lo = '0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) saw_done++;
    end
    chk("rst_mid_no_done", saw_done, 0);
    run_div(32'd9, 32'd3, 0, 0, 0);

    // Killed start is squashed.
    @(negedge clk);
    bus.div_start = 1'b1; bus.kill = 1'b1; bus.id_mfhilo = 1'b1;
    bus.dividend = 32'd50; bus.divisor = 32'd5;
    #1 chk("kill_stall", bus.stall, 0);
    @(posedge clk);
    @(negedge clk);
    bus.div_start = 1'b0; bus.kill = 1'b0; bus.id_mfhilo = 1'b0;
    #1;
    chk("kill_busy", bus.busy, 0);
    chk("kill_done", bus.done, 0);
    chk("kill_hi", bus.hi, m_hi);

    run_div(32'd5, 32'd9, 1, 0, 0);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0: begin dvd = $urandom; dvs = 0; end
        1: begin dvd = $urandom; dvs = $urandom_range(1, 255); end
        2: begin dvd = $urandom; dvs = $urandom; end
        default: begin dvd = $urandom_range(0, 1000); dvs = $urandom_range(1001, 100000); end
      endcase
      run_div(dvd, dvs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
